wb_master_bridge: RTL and testbench

Wishbone classic single-transfer initiator. It is the master-side counterpart of the user-project Wishbone slave port. It accepts read/write commands on a valid/ready command channel and runs one Wishbone B4 classic cycle per command. It returns read data and status on a valid/ready response channel. Built-in test engines and LA-driven bring-up logic use it to drive the accelerator's slave port.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_timeout_ctr.sv | 37 +++
 rtl/wb_master_bridge.sv | 157 +++++++++++++++
 tb/tb_wb_master_bridge.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic single-transfer initiator:
// bus widths, FSM state encoding, error-response data and an address helper.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    // Data returned alongside rsp_err=1 after an aborted transfer
    localparam logic [WB_DAT_W-1:0] RSP_ERR_DATA = 32'h0000_0000;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Force a byte address onto a 32-bit word boundary
    function automatic logic [WB_ADR_W-1:0] word_align(input logic [WB_ADR_W-1:0] adr);
        return {adr[WB_ADR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-phase watchdog for wb_master_bridge. Counts cycles spent waiting for
// an acknowledge and flags expiry once TIMEOUT_CYCLES-1 has been reached, so
// that the strobe is held for exactly TIMEOUT_CYCLES cycles.
// Only instantiated when WBM_TIMEOUT_EN is defined.
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // A one-cycle limit still needs a 1-bit counter
    localparam int CTR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CTR_W-1:0] LAST_CNT = CTR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

    logic [CTR_W-1:0] r_count;

    // Wait-cycle counter: cleared on command acceptance, stops at the limit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {CTR_W{1'b0}};
        end else if (i_clear) begin
            r_count <= {CTR_W{1'b0}};
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CTR_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LAST_CNT);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic single-transfer initiator. Takes one read/write command
// on a valid/ready channel, runs one classic cycle and returns data/status on
// a valid/ready response channel. Command and response never overlap.
// Optional feature macro: WBM_TIMEOUT_EN (abort a bus cycle with rsp_err=1
// after TIMEOUT_CYCLES cycles without acknowledge). Without it the bus phase
// waits indefinitely and rsp_err is constant 0.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic [CNT_W-1:0]    txn_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) || (CNT_W < 1)) begin : g_bad_param
        $error("wb_master_bridge: TIMEOUT_CYCLES must be 1..65535 and CNT_W >= 1");
    end

    wb_state_e           r_state;
    logic                r_rsp_valid;
    logic [WB_DAT_W-1:0] r_rsp_dat;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [WB_SEL_W-1:0] r_sel;
    logic [WB_ADR_W-1:0] r_adr;
    logic [WB_DAT_W-1:0] r_dat;
    logic [CNT_W-1:0]    r_txn_count;
    logic                w_cmd_accept;

    assign cmd_ready    = (r_state == IDLE);
    assign w_cmd_accept = cmd_valid && cmd_ready;

`ifdef WBM_TIMEOUT_EN
    logic w_tmo_enable;
    logic w_tmo_expired;
    logic r_rsp_err;

    // Count only while the slave keeps us waiting
    assign w_tmo_enable = (r_state == BUS) && !wbm_ack_i;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_clear   (w_cmd_accept),
        .i_enable  (w_tmo_enable),
        .o_expired (w_tmo_expired)
    );

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    // Bridge FSM: latch command, run the bus cycle, hold the response
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'h0000_0000;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'h0;
            r_adr       <= 32'h0000_0000;
            r_dat       <= 32'h0000_0000;
            r_txn_count <= {CNT_W{1'b0}};
`ifdef WBM_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_accept) begin
                        r_adr   <= word_align(cmd_adr);
                        r_we    <= cmd_we;
                        r_sel   <= cmd_sel;
                        r_dat   <= cmd_dat;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a same-edge timeout
                    if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_dat   <= r_we ? 32'h0000_0000 : wbm_dat_i;
                        r_rsp_valid <= 1'b1;
                        r_txn_count <= r_txn_count + CNT_ONE;
                        r_state     <= RESP;
`ifdef WBM_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
                    end else if (w_tmo_expired) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_dat   <= RSP_ERR_DATA;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_txn_count <= r_txn_count + CNT_ONE;
                        r_state     <= RESP;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_cyc       <= 1'b0;
                    r_stb       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: directed scenarios plus a
// randomized stream checked against a word-addressed memory reference model.
// The timeout scenarios are compiled only when WBM_TIMEOUT_EN is defined.
module tb_wb_master_bridge;

    localparam int TB_TMO   = 8;
    localparam int TB_CNT_W = 8;
    localparam int N_STRESS = 1000;

    logic                clk;
    logic                wb_rst_i;
    logic                cmd_valid, cmd_ready, cmd_we;
    logic [31:0]         cmd_adr, cmd_dat;
    logic [3:0]          cmd_sel;
    logic                rsp_valid, rsp_ready, rsp_err;
    logic [31:0]         rsp_dat;
    logic                wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]          wbm_sel_o;
    logic [31:0]         wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [TB_CNT_W-1:0] txn_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    // Reference memory (command side) and slave memory (bus side), both word keyed
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] slv_mem [logic [29:0]];
    bit          slave_en = 1'b0;
    int          slave_wait = 0;
    int          slave_wcnt = 0;

    // Bus-phase snapshot taken by run_cmd
    logic [31:0] bus_adr, bus_dat;
    logic [3:0]  bus_sel;
    logic        bus_we;
    bit          bus_stable;

    wb_master_bridge #(
        .TIMEOUT_CYCLES (TB_TMO),
        .CNT_W          (TB_CNT_W)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .txn_count (txn_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [31:0] init_word(input logic [29:0] key);
        return {key, 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] key);
        if (ref_mem.exists(key)) return ref_mem[key];
        return init_word(key);
    endfunction

    // Behavioural Wishbone slave with programmable wait states
    initial begin
        logic [29:0] key;
        logic [31:0] old;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (slave_en) begin
                if (wbm_cyc_o && wbm_stb_o) begin
                    if (slave_wcnt >= slave_wait) begin
                        wbm_ack_i  = 1'b1;
                        key        = wbm_adr_o[31:2];
                        old        = slv_mem.exists(key) ? slv_mem[key] : init_word(key);
                        if (wbm_we_o) begin
                            slv_mem[key] = merge(old, wbm_dat_o, wbm_sel_o);
                            wbm_dat_i    = $urandom;
                        end else begin
                            wbm_dat_i    = old;
                        end
                        slave_wcnt = 0;
                    end else begin
                        wbm_ack_i  = 1'b0;
                        wbm_dat_i  = $urandom;
                        slave_wcnt = slave_wcnt + 1;
                    end
                end else begin
                    wbm_ack_i  = 1'b0;
                    wbm_dat_i  = $urandom;
                    slave_wcnt = 0;
                end
            end else begin
                slave_wcnt = 0;
            end
        end
    end

    task automatic apply_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        wb_rst_i  = 1'b1;
        repeat (2) @(posedge clk);
        #1 wb_rst_i = 1'b0;
        exp_count = 0;
    endtask

    // Issue one command, observe the bus phase, collect and retire the response
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int rsp_delay, input bit early_ready,
                           output logic [31:0] o_dat, output logic o_err, output int o_stb,
                           output int o_lat, output logic o_cyc_at_rsp);
        bit got;
        int dly;
        o_dat = 32'h0; o_err = 1'b0; o_stb = 0; o_lat = 0; o_cyc_at_rsp = 1'b0;
        bus_stable = 1'b1;
        dly = early_ready ? 0 : rsp_delay;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        rsp_ready = early_ready;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cmd_ready;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=0, required 1 within 20 cycles");
            apply_reset();
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom); cmd_we = 1'($urandom);
        got = 1'b0;
        for (int k = 1; k <= 64 && !got; k++) begin
            @(negedge clk);
            if (wbm_stb_o) begin
                if (o_stb == 0) begin
                    bus_adr = wbm_adr_o; bus_dat = wbm_dat_o; bus_sel = wbm_sel_o; bus_we = wbm_we_o;
                end else if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o} !==
                             {bus_adr, bus_dat, bus_sel, bus_we, 1'b1}) begin
                    bus_stable = 1'b0;
                end
                o_stb++;
            end
            if (rsp_valid) begin
                got = 1'b1; o_lat = k; o_dat = rsp_dat; o_err = rsp_err;
                o_cyc_at_rsp = wbm_cyc_o | wbm_stb_o;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rsp_wait: rsp_valid=0, required 1 within 64 cycles");
            apply_reset();
            return;
        end
        for (int d = 0; d < dly; d++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_dat, rsp_err, cmd_ready, wbm_cyc_o} !== {1'b1, o_dat, o_err, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rsp_hold: got v=%b d=%h e=%b rdy=%b cyc=%b, required v=1 d=%h e=%b rdy=0 cyc=0",
                         rsp_valid, rsp_dat, rsp_err, cmd_ready, wbm_cyc_o, o_dat, o_err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/v/e/cyc/stb/we/sel=%b, required 1000000000",
                     {cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o});
        end
        checks++;
        if ({wbm_adr_o, wbm_dat_o, rsp_dat} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got adr=%h dat=%h rsp_dat=%h, required all 0", wbm_adr_o, wbm_dat_o, rsp_dat);
        end
        checks++;
        if (txn_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", txn_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        logic [31:0] d; logic e, c; int s, l;
        logic [29:0] key;
        logic [31:0] adr;
        adr = 32'h3000_0007;
        key = adr[31:2];
        ref_mem[key] = merge(ref_read(key), 32'hA5A5_1234, 4'hF);
        slave_en = 1'b1; slave_wait = 2;
        run_cmd(1'b1, adr, 32'hA5A5_1234, 4'hF, 0, 1'b0, d, e, s, l, c);
        checks++;
        if ({bus_adr, bus_dat, bus_sel, bus_we} !== {32'h3000_0004, 32'hA5A5_1234, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL write_bus: got adr=%h dat=%h sel=%h we=%b, required 30000004 a5a51234 f 1",
                     bus_adr, bus_dat, bus_sel, bus_we);
        end
        checks++;
        if (bus_stable !== 1'b1 || s != 3) begin
            errors++;
            $display("FAIL write_hold: got stable=%b stb_cycles=%0d, required 1 and 3", bus_stable, s);
        end
        checks++;
        if ({d, e} !== {32'h0, 1'b0} || l != 4) begin
            errors++;
            $display("FAIL write_rsp: got dat=%h err=%b lat=%0d, required 0 0 4", d, e, l);
        end
        checks++;
        if (txn_count !== 8'd1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_count: got count=%0d rdy=%b, required 1 and 1", txn_count, cmd_ready);
        end
    endtask

    task automatic test_read();
        logic [31:0] d; logic e, c; int s, l;
        logic [31:0] adr;
        logic [29:0] key;
        adr = 32'h3000_0010;
        key = adr[31:2];
        slv_mem[key] = 32'hCAFE_F00D;
        ref_mem[key] = 32'hCAFE_F00D;
        slave_en = 1'b1; slave_wait = 0;
        run_cmd(1'b0, adr, $urandom, 4'hF, 0, 1'b0, d, e, s, l, c);
        checks++;
        if ({d, e} !== {32'hCAFE_F00D, 1'b0} || l != 2 || s != 1) begin
            errors++;
            $display("FAIL read_rsp: got dat=%h err=%b lat=%0d stb=%0d, required cafef00d 0 2 1", d, e, l, s);
        end
        checks++;
        if (c !== 1'b0 || bus_we !== 1'b0) begin
            errors++;
            $display("FAIL read_bus: got cyc_after_ack=%b we=%b, required 0 0", c, bus_we);
        end
        adr = 32'h3000_0006;
        run_cmd(1'b0, adr, $urandom, 4'h3, 0, 1'b0, d, e, s, l, c);
        checks++;
        if (d !== 32'hA5A5_1234 || bus_adr !== 32'h3000_0004) begin
            errors++;
            $display("FAIL readback: got dat=%h adr=%h, required a5a51234 30000004", d, bus_adr);
        end
    endtask

    task automatic test_stray_ack();
        slave_en = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, wbm_cyc_o, cmd_ready} !== 3'b001 || txn_count !== exp_count[TB_CNT_W-1:0]) begin
                errors++;
                $display("FAIL stray_ack: got v/cyc/rdy=%b count=%0d, required 001 count=%0d",
                         {rsp_valid, wbm_cyc_o, cmd_ready}, txn_count, exp_count[TB_CNT_W-1:0]);
            end
        end
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
        slave_en = 1'b1;
    endtask

    task automatic test_backpressure();
        bit got;
        slave_en = 1'b1; slave_wait = 0;
        cmd_we = 1'b0; cmd_adr = 32'h3000_0004; cmd_sel = 4'hF; cmd_dat = $urandom; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_adr = 32'h3000_0010;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        checks++;
        if (!got || rsp_dat !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL bp_first: got v=%b dat=%h, required 1 a5a51234", got, rsp_dat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o} !== {1'b1, 32'hA5A5_1234, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold: got v=%b dat=%h rdy=%b cyc=%b, required 1 a5a51234 0 0",
                         rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_count++;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, wbm_cyc_o} !== 3'b100) begin
            errors++;
            $display("FAIL bp_release: got rdy/v/cyc=%b, required 100", {cmd_ready, rsp_valid, wbm_cyc_o});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wbm_stb_o !== 1'b1 || wbm_adr_o !== 32'h3000_0010) begin
            errors++;
            $display("FAIL bp_second: got stb=%b adr=%h, required 1 30000010", wbm_stb_o, wbm_adr_o);
        end
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (k > 0) @(negedge clk);
            got = rsp_valid;
        end
        checks++;
        if (!got || rsp_dat !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL bp_second_rsp: got v=%b dat=%h, required 1 cafef00d", got, rsp_dat);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_count++;
        checks++;
        if (txn_count !== exp_count[TB_CNT_W-1:0]) begin
            errors++;
            $display("FAIL bp_count: got %0d, required %0d", txn_count, exp_count[TB_CNT_W-1:0]);
        end
    endtask

`ifdef WBM_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] d; logic e, c; int s, l;
        slave_en = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h1234_5678;
        run_cmd(1'b0, 32'h3000_0020, $urandom, 4'hF, 2, 1'b0, d, e, s, l, c);
        checks++;
        if (s != TB_TMO || l != TB_TMO + 1) begin
            errors++;
            $display("FAIL tmo_len: got stb_cycles=%0d lat=%0d, required %0d %0d", s, l, TB_TMO, TB_TMO + 1);
        end
        checks++;
        if ({d, e} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL tmo_rsp: got dat=%h err=%b, required 0 1", d, e);
        end
        wbm_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || txn_count !== exp_count[TB_CNT_W-1:0]) begin
            errors++;
            $display("FAIL tmo_late_ack: got v=%b count=%0d, required 0 %0d", rsp_valid, txn_count, exp_count[TB_CNT_W-1:0]);
        end
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
        slave_en = 1'b1; slave_wait = TB_TMO - 1;
        run_cmd(1'b0, 32'h3000_0010, $urandom, 4'hF, 0, 1'b0, d, e, s, l, c);
        checks++;
        if ({d, e} !== {32'hCAFE_F00D, 1'b0} || s != TB_TMO) begin
            errors++;
            $display("FAIL tmo_ack_wins: got dat=%h err=%b stb=%0d, required cafef00d 0 %0d", d, e, s, TB_TMO);
        end
    endtask
`endif

    task automatic test_reset_mid_bus();
        slave_en = 1'b0;
        wbm_ack_i = 1'b0;
        cmd_we = 1'b1; cmd_adr = 32'h3000_0030; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wbm_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got stb=%b, required 1", wbm_stb_o);
        end
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        exp_count = 0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 10'b10_0000_0000 ||
            {wbm_adr_o, wbm_dat_o, rsp_dat} !== 96'h0 || txn_count !== 8'h00) begin
            errors++;
            $display("FAIL midrst_vals: got ctrl=%b adr=%h dat=%h rdat=%h cnt=%0d, required 1000000000 0 0 0 0",
                     {cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o},
                     wbm_adr_o, wbm_dat_o, rsp_dat, txn_count);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle: got v=%b cyc=%b, required 0 0", rsp_valid, wbm_cyc_o);
            end
        end
        @(posedge clk); #1;
        slave_en = 1'b1;
    endtask

    task automatic test_stress();
        logic [31:0] d, adr, dat, exp_d; logic e, c, we; int s, l;
        logic [3:0] sel;
        logic [29:0] key;
        slave_en = 1'b1;
        for (int i = 0; i < N_STRESS; i++) begin
            we  = 1'($urandom_range(0, 1));
            adr = 32'h3000_0000 | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            dat = $urandom;
            sel = 4'($urandom_range(0, 15));
            key = adr[31:2];
            if (we) begin
                exp_d = 32'h0;
                ref_mem[key] = merge(ref_read(key), dat, sel);
            end else begin
                exp_d = ref_read(key);
            end
            slave_wait = $urandom_range(0, 3);
            run_cmd(we, adr, dat, sel, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                    d, e, s, l, c);
            checks++;
            if ({d, e} !== {exp_d, 1'b0}) begin
                errors++;
                $display("FAIL stress_rsp[%0d]: got dat=%h err=%b, required %h 0 (we=%b adr=%h)", i, d, e, exp_d, we, adr);
            end
            checks++;
            if (bus_stable !== 1'b1 || bus_adr !== {adr[31:2], 2'b00} || bus_we !== we) begin
                errors++;
                $display("FAIL stress_bus[%0d]: got stable=%b adr=%h we=%b, required 1 %h %b",
                         i, bus_stable, bus_adr, bus_we, {adr[31:2], 2'b00}, we);
            end
            checks++;
            if (txn_count !== exp_count[TB_CNT_W-1:0]) begin
                errors++;
                $display("FAIL stress_count[%0d]: got %0d, required %0d", i, txn_count, exp_count[TB_CNT_W-1:0]);
            end
        end
    endtask

    initial begin
        wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
        cmd_sel = 4'h0; rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stray_ack();
        test_backpressure();
`ifdef WBM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_bus();
        test_stress();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
